// File: rtl/sync_pkt_fifo_pkg.sv
// Shared helpers and types for the frame-aware packet FIFO.
// Depth rounding helpers live here so the top and RAM agree on geometry.
package sync_pkt_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int clog2s(input int value);
    int r;
    r = clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int pow2_ceil(input int value);
    return 1 << clog2s(value);
  endfunction

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_DISCARD,
    WR_REWIND
  } wr_action_e;

endpackage

// File: rtl/sync_pkt_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: one write port, one synchronous read port.
// RAM_STYLE selects the implementation hint given to synthesis.
module sync_pkt_fifo_ram #(
  parameter int WIDTH     = 65,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int RAM_STYLE = 1
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  if (RAM_STYLE != 0) begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) rd_q <= mem[i_rd_addr];
    end

    assign o_rd_data = rd_q;
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge i_clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) rd_q <= mem[i_rd_addr];
    end

    assign o_rd_data = rd_q;
  end

endmodule

// File: rtl/sync_pkt_fifo.sv
// Single-clock frame-aware FIFO: speculative writes commit on the last word, frames can be
// dropped mid-write or on overflow; FWFT or standard read port, flags and frame count.
module sync_pkt_fifo
  import sync_pkt_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH    = 64,
  parameter  int FIFO_DEPTH    = 256,
  parameter  int FWFT_MODE     = 1,
  parameter  int AFULL_THRESH  = pow2_ceil(FIFO_DEPTH) - 4,
  parameter  int AEMPTY_THRESH = 4,
  parameter  int RAM_STYLE     = 1,
  localparam int REAL_DEPTH    = pow2_ceil(FIFO_DEPTH),
  localparam int PTR_WIDTH     = clog2s(REAL_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_last,
  input  logic                  i_wr_drop,
  output logic                  o_wr_full,
  output logic                  o_wr_afull,
  output logic [PTR_WIDTH:0]    o_wr_cnt,
  output logic                  o_wr_overflow,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_rd_valid,
  output logic                  o_rd_empty,
  output logic                  o_rd_aempty,
  output logic [PTR_WIDTH:0]    o_rd_cnt,
  output logic [PTR_WIDTH:0]    o_pkt_cnt
);

  localparam int MEM_WIDTH = DATA_WIDTH + 1;

  typedef logic [PTR_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH_P  = ptr_t'(REAL_DEPTH);
  localparam ptr_t AFULL_P  = ptr_t'(AFULL_THRESH);
  localparam ptr_t AEMPTY_P = ptr_t'(AEMPTY_THRESH);

  ptr_t       wptr_spec_q, wptr_spec_d;
  ptr_t       wptr_cmt_q, wptr_cmt_d;
  ptr_t       rptr_q, rptr_d;
  ptr_t       wr_cnt_q, wr_cnt_d;
  ptr_t       rd_cnt_q, rd_cnt_d;
  ptr_t       pkt_cnt_q, pkt_cnt_d;
  logic       frame_err_q, frame_err_d;
  logic       wr_full_q, wr_afull_q, wr_ovf_q, rd_aempty_q;
  wr_action_e wr_act;
  logic       commit;
  logic       rd_pop;
  logic       pkt_dec;
  logic       ram_rd_en;
  logic [PTR_WIDTH-1:0] ram_rd_addr;
  logic [MEM_WIDTH-1:0] ram_dout;

  // Drop always wins; once a frame has overflowed, everything up to its last word is discarded.
  always_comb begin
    wr_act = WR_IDLE;
    if (i_wr_drop) begin
      wr_act = WR_REWIND;
    end else if (i_wr_en) begin
      if (wr_full_q)        wr_act = i_wr_last ? WR_REWIND : WR_DISCARD;
      else if (frame_err_q) wr_act = i_wr_last ? WR_REWIND : WR_IDLE;
      else                  wr_act = WR_ACCEPT;
    end
  end

  always_comb begin
    wptr_spec_d = wptr_spec_q;
    wptr_cmt_d  = wptr_cmt_q;
    frame_err_d = frame_err_q;
    commit      = 1'b0;
    case (wr_act)
      WR_ACCEPT: begin
        wptr_spec_d = wptr_spec_q + ptr_t'(1);
        if (i_wr_last) begin
          commit     = 1'b1;
          wptr_cmt_d = wptr_spec_q + ptr_t'(1);
        end
      end
      WR_DISCARD: frame_err_d = 1'b1;
      WR_REWIND: begin
        wptr_spec_d = wptr_cmt_q;
        frame_err_d = 1'b0;
      end
      default: ;
    endcase
    rptr_d    = rptr_q + ptr_t'(rd_pop);
    wr_cnt_d  = wptr_spec_d - rptr_d;
    rd_cnt_d  = wptr_cmt_d - rptr_d;
    pkt_cnt_d = pkt_cnt_q + ptr_t'(commit) - ptr_t'(pkt_dec);
  end

  // Flags are computed from next-state pointers so they track the registered pointers exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_spec_q <= '0;
      wptr_cmt_q  <= '0;
      rptr_q      <= '0;
      frame_err_q <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      pkt_cnt_q   <= '0;
      wr_full_q   <= 1'b0;
      wr_afull_q  <= 1'b0;
      wr_ovf_q    <= 1'b0;
      rd_aempty_q <= 1'b1;
    end else begin
      wptr_spec_q <= wptr_spec_d;
      wptr_cmt_q  <= wptr_cmt_d;
      rptr_q      <= rptr_d;
      frame_err_q <= frame_err_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      wr_full_q   <= (wr_cnt_d == DEPTH_P);
      wr_afull_q  <= (wr_cnt_d >= AFULL_P);
      wr_ovf_q    <= i_wr_en & wr_full_q & ~i_wr_drop;
      rd_aempty_q <= (rd_cnt_d <= AEMPTY_P);
    end
  end

  assign o_wr_full     = wr_full_q;
  assign o_wr_afull    = wr_afull_q;
  assign o_wr_cnt      = wr_cnt_q;
  assign o_wr_overflow = wr_ovf_q;
  assign o_rd_aempty   = rd_aempty_q;
  assign o_rd_cnt      = rd_cnt_q;
  assign o_pkt_cnt     = pkt_cnt_q;

  sync_pkt_fifo_ram #(
    .WIDTH    (MEM_WIDTH),
    .DEPTH    (REAL_DEPTH),
    .ADDR_W   (PTR_WIDTH),
    .RAM_STYLE(RAM_STYLE)
  ) u_ram (
    .i_clk    (i_clk),
    .i_wr_en  (wr_act == WR_ACCEPT),
    .i_wr_addr(wptr_spec_q[PTR_WIDTH-1:0]),
    .i_wr_data({i_wr_last, i_wr_data}),
    .i_rd_en  (ram_rd_en),
    .i_rd_addr(ram_rd_addr),
    .o_rd_data(ram_dout)
  );

  if (FWFT_MODE != 0) begin : g_fwft
    // Two-stage prefetch: RAM output stage feeds the output register, keeping 1 word/clk.
    ptr_t                  raddr_q;
    logic                  ram_vld_q, out_vld_q, out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  load_out, fetch;

    assign rd_pop      = i_rd_en & out_vld_q;
    assign load_out    = ram_vld_q & (~out_vld_q | rd_pop);
    assign fetch       = (raddr_q != wptr_cmt_q) & (~ram_vld_q | load_out);
    assign ram_rd_en   = fetch;
    assign ram_rd_addr = raddr_q[PTR_WIDTH-1:0];
    assign pkt_dec     = rd_pop & out_last_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        raddr_q    <= '0;
        ram_vld_q  <= 1'b0;
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
        out_last_q <= 1'b0;
      end else begin
        if (fetch) raddr_q <= raddr_q + ptr_t'(1);
        ram_vld_q <= fetch | (ram_vld_q & ~load_out);
        out_vld_q <= load_out | (out_vld_q & ~rd_pop);
        if (load_out) begin
          out_data_q <= ram_dout[DATA_WIDTH-1:0];
          out_last_q <= ram_dout[DATA_WIDTH];
        end
      end
    end

    assign o_rd_valid = out_vld_q;
    assign o_rd_empty = ~out_vld_q;
    assign o_rd_data  = out_data_q;
    assign o_rd_last  = out_last_q;
  end else begin : g_std
    logic empty_q, vld_q;

    assign rd_pop      = i_rd_en & ~empty_q;
    assign ram_rd_en   = rd_pop;
    assign ram_rd_addr = rptr_q[PTR_WIDTH-1:0];
    // The last flag is only known once the word leaves the RAM, one cycle after the pop.
    assign pkt_dec     = vld_q & ram_dout[DATA_WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        empty_q <= 1'b1;
        vld_q   <= 1'b0;
      end else begin
        empty_q <= (wptr_cmt_d == rptr_d);
        vld_q   <= rd_pop;
      end
    end

    assign o_rd_valid = vld_q;
    assign o_rd_empty = empty_q;
    assign o_rd_data  = vld_q ? ram_dout[DATA_WIDTH-1:0] : '0;
    assign o_rd_last  = vld_q & ram_dout[DATA_WIDTH];
  end

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Scoreboard bench for sync_pkt_fifo: an FWFT instance driven by a frame-level model
// and a standard-read instance exercised with directed sequences.
module tb_sync_pkt_fifo;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          fw_wr_en, fw_wr_last, fw_wr_drop, fw_rd_en;
  logic [DW-1:0] fw_wr_data;
  logic          fw_wr_full, fw_wr_afull, fw_wr_ovf;
  logic [4:0]    fw_wr_cnt, fw_rd_cnt, fw_pkt_cnt;
  logic [DW-1:0] fw_rd_data;
  logic          fw_rd_last, fw_rd_valid, fw_rd_empty, fw_rd_aempty;

  logic          sd_wr_en, sd_wr_last, sd_wr_drop, sd_rd_en;
  logic [DW-1:0] sd_wr_data;
  logic          sd_wr_full, sd_wr_afull, sd_wr_ovf;
  logic [4:0]    sd_wr_cnt, sd_rd_cnt, sd_pkt_cnt;
  logic [DW-1:0] sd_rd_data;
  logic          sd_rd_last, sd_rd_valid, sd_rd_empty, sd_rd_aempty;

  sync_pkt_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .FWFT_MODE(1)) u_dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(fw_wr_en), .i_wr_data(fw_wr_data), .i_wr_last(fw_wr_last), .i_wr_drop(fw_wr_drop),
    .o_wr_full(fw_wr_full), .o_wr_afull(fw_wr_afull), .o_wr_cnt(fw_wr_cnt), .o_wr_overflow(fw_wr_ovf),
    .i_rd_en(fw_rd_en), .o_rd_data(fw_rd_data), .o_rd_last(fw_rd_last), .o_rd_valid(fw_rd_valid),
    .o_rd_empty(fw_rd_empty), .o_rd_aempty(fw_rd_aempty), .o_rd_cnt(fw_rd_cnt), .o_pkt_cnt(fw_pkt_cnt)
  );

  sync_pkt_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .FWFT_MODE(0)) u_dut_std (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(sd_wr_en), .i_wr_data(sd_wr_data), .i_wr_last(sd_wr_last), .i_wr_drop(sd_wr_drop),
    .o_wr_full(sd_wr_full), .o_wr_afull(sd_wr_afull), .o_wr_cnt(sd_wr_cnt), .o_wr_overflow(sd_wr_ovf),
    .i_rd_en(sd_rd_en), .o_rd_data(sd_rd_data), .o_rd_last(sd_rd_last), .o_rd_valid(sd_rd_valid),
    .o_rd_empty(sd_rd_empty), .o_rd_aempty(sd_rd_aempty), .o_rd_cnt(sd_rd_cnt), .o_pkt_cnt(sd_pkt_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW:0] pend[$];
  logic [DW:0] sb[$];
  int  m_spec, m_cmt, m_pkt;
  bit  m_err;
  logic [DW-1:0] seq = 16'h1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    sb.delete();
    m_spec = 0;
    m_cmt  = 0;
    m_pkt  = 0;
    m_err  = 0;
  endtask

  task automatic clear_frame();
    pend.delete();
    m_spec = 0;
    m_err  = 0;
  endtask

  // One clock of the FWFT instance; inputs driven #1 after the edge, outputs checked #1 after the next.
  task automatic cyc(input logic we, input logic [DW-1:0] d, input logic last,
                     input logic drop, input logic re);
    logic [DW:0] w;
    bit full, ovf_exp;
    int wcnt;
    fw_wr_en = we; fw_wr_data = d; fw_wr_last = last; fw_wr_drop = drop; fw_rd_en = re;
    full    = (m_spec + m_cmt) == 16;
    ovf_exp = 0;
    if (re && fw_rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_extra_word", fw_rd_valid, 0);
      end else begin
        w = sb.pop_front();
        chk("rd_data", fw_rd_data, w[DW-1:0]);
        chk("rd_last", fw_rd_last, w[DW]);
        m_cmt--;
        if (w[DW]) m_pkt--;
      end
    end
    if (drop) begin
      clear_frame();
    end else if (we) begin
      if (full) begin
        ovf_exp = 1;
        if (last) clear_frame();
        else m_err = 1;
      end else if (m_err) begin
        if (last) clear_frame();
      end else begin
        pend.push_back({last, d});
        m_spec++;
        if (last) begin
          foreach (pend[i]) sb.push_back(pend[i]);
          m_cmt += m_spec;
          m_pkt++;
          pend.delete();
          m_spec = 0;
        end
      end
    end
    @(posedge clk); #1;
    wcnt = m_spec + m_cmt;
    chk("wr_cnt", fw_wr_cnt, wcnt);
    chk("rd_cnt", fw_rd_cnt, m_cmt);
    chk("pkt_cnt", fw_pkt_cnt, m_pkt);
    chk("wr_full", fw_wr_full, (wcnt == 16));
    chk("wr_afull", fw_wr_afull, (wcnt >= 12));
    chk("rd_aempty", fw_rd_aempty, (m_cmt <= 4));
    chk("wr_overflow", fw_wr_ovf, ovf_exp);
    if (sb.size() == 0) chk("valid_without_data", fw_rd_valid, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      cyc(0, '0, 0, 0, 1);
      n++;
    end
    chk("drain_leftover", sb.size(), 0);
    idle(2);
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) begin
      cyc(1, seq, (i == len - 1), 0, 0);
      seq++;
    end
  endtask

  task automatic sd_step(input logic we, input logic [DW-1:0] d, input logic last, input logic re);
    sd_wr_en = we; sd_wr_data = d; sd_wr_last = last; sd_rd_en = re;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fw_valid"}, fw_rd_valid, 0);
    chk({tag, "_fw_empty"}, fw_rd_empty, 1);
    chk({tag, "_fw_aempty"}, fw_rd_aempty, 1);
    chk({tag, "_fw_full"}, fw_wr_full, 0);
    chk({tag, "_fw_afull"}, fw_wr_afull, 0);
    chk({tag, "_fw_ovf"}, fw_wr_ovf, 0);
    chk({tag, "_fw_wr_cnt"}, fw_wr_cnt, 0);
    chk({tag, "_fw_rd_cnt"}, fw_rd_cnt, 0);
    chk({tag, "_fw_pkt_cnt"}, fw_pkt_cnt, 0);
    chk({tag, "_fw_rd_data"}, fw_rd_data, 0);
    chk({tag, "_fw_rd_last"}, fw_rd_last, 0);
    chk({tag, "_sd_valid"}, sd_rd_valid, 0);
    chk({tag, "_sd_empty"}, sd_rd_empty, 1);
    chk({tag, "_sd_rd_data"}, sd_rd_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    fw_wr_en = 0; fw_wr_data = '0; fw_wr_last = 0; fw_wr_drop = 0; fw_rd_en = 0;
    sd_wr_en = 0; sd_wr_data = '0; sd_wr_last = 0; sd_wr_drop = 0; sd_rd_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    idle(2);

    // Frame commit, FWFT latency and in-order readback
    send_frame(4);
    chk("vld_at_commit", fw_rd_valid, 0);
    idle(1);
    chk("vld_commit_p1", fw_rd_valid, 0);
    idle(1);
    chk("vld_commit_p2", fw_rd_valid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", fw_rd_valid, 1);
      cyc(0, '0, 0, 0, 1);
    end
    idle(2);

    // Drop after three words, then a clean two-word frame
    for (int i = 0; i < 3; i++) begin
      cyc(1, seq, 0, 0, 0);
      seq++;
    end
    cyc(0, '0, 0, 1, 0);
    idle(3);
    chk("drop_empty", fw_rd_empty, 1);
    send_frame(2);
    idle(2);
    drain();

    // 20-word frame into a 16-deep FIFO with no reads
    for (int i = 1; i <= 20; i++) begin
      cyc(1, seq, (i == 20), 0, 0);
      seq++;
      if (i == 15) chk("full_before16", fw_wr_full, 0);
      if (i == 16) chk("full_at16", fw_wr_full, 1);
    end
    idle(3);
    chk("ovf_frame_cnt", fw_wr_cnt, 0);
    chk("ovf_frame_valid", fw_rd_valid, 0);

    // Streaming frames with random reads, occasional drops, pointer wrap
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        cyc(1, seq, (i == len - 1), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        seq++;
      end
      if ($urandom_range(0, 2) == 0) cyc(0, '0, 0, 0, ($urandom_range(0, 1) == 1));
    end
    drain();

    // Standard read mode
    fw_wr_en = 0; fw_rd_en = 0; fw_wr_drop = 0;
    sd_step(1, 16'hA001, 0, 0);
    sd_step(1, 16'hA002, 1, 0);
    chk("sd_cnt_commit", sd_rd_cnt, 2);
    chk("sd_empty_commit", sd_rd_empty, 0);
    chk("sd_valid_idle", sd_rd_valid, 0);
    sd_step(0, '0, 0, 1);
    chk("sd_pop1_valid", sd_rd_valid, 1);
    chk("sd_pop1_data", sd_rd_data, 16'hA001);
    chk("sd_pop1_last", sd_rd_last, 0);
    chk("sd_pop1_cnt", sd_rd_cnt, 1);
    sd_step(0, '0, 0, 0);
    chk("sd_gap_valid", sd_rd_valid, 0);
    sd_step(0, '0, 0, 1);
    chk("sd_pop2_data", sd_rd_data, 16'hA002);
    chk("sd_pop2_last", sd_rd_last, 1);
    chk("sd_pop2_empty", sd_rd_empty, 1);
    sd_step(0, '0, 0, 0);
    chk("sd_pkt_after", sd_pkt_cnt, 0);
    sd_step(0, '0, 0, 1);
    chk("sd_pop_empty_valid", sd_rd_valid, 0);
    chk("sd_pop_empty_cnt", sd_rd_cnt, 0);
    chk("sd_pop_empty_wcnt", sd_wr_cnt, 0);
    sd_step(0, '0, 0, 0);

    // Threshold edges on the standard instance
    for (int i = 1; i <= 12; i++) begin
      sd_step(1, DW'(16'h0100 + i), (i == 12), 0);
      chk("sd_afull_wr", sd_wr_afull, (i >= 12));
      chk("sd_aempty_wr", sd_rd_aempty, (i < 12));
    end
    for (int k = 1; k <= 12; k++) begin
      sd_step(0, '0, 0, 1);
      chk("sd_thr_data", sd_rd_data, DW'(16'h0100 + k));
      chk("sd_thr_cnt", sd_rd_cnt, 12 - k);
      chk("sd_afull_rd", sd_wr_afull, ((12 - k) >= 12));
      chk("sd_aempty_rd", sd_rd_aempty, ((12 - k) <= 4));
    end
    sd_step(0, '0, 0, 0);
    chk("sd_thr_pkt", sd_pkt_cnt, 0);

    // Asynchronous reset mid-read and mid-frame
    send_frame(3);
    idle(3);
    cyc(0, '0, 0, 0, 1);
    cyc(1, seq, 0, 0, 0);
    seq++;
    cyc(1, seq, 0, 0, 0);
    seq++;
    fw_wr_en = 0; fw_rd_en = 0;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(1);
    send_frame(3);
    idle(3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
